// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with pixel divider,
// frame-latched pixel scaling, freeze enable and frame counter.
// Ports: clk, rst (async high); en freezes all state; scale = x/y shift
// (taken at frame start); pix_tick pixel strobe; hsync/vsync/de/x/y
// raster outputs; line_start/frame_start pulses; frame_cnt frames begun.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   PIX_DIV  = 1,
  parameter int   CNT_W    = 10,
  parameter int   FRAME_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         scale,
  output logic               pix_tick,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [CNT_W-1:0]   x,
  output logic [CNT_W-1:0]   y,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SE   =
    CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);

  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SE   =
    CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
  localparam logic [FRAME_W-1:0] FRM_ONE = FRAME_W'(1);

  // counters and latched scale
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]   h_q, h_d;
  logic [CNT_W-1:0]   v_q, v_d;
  logic [1:0]         scale_q, scale_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

  // registered outputs
  logic               pix_tick_q, pix_tick_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               de_q, de_d;
  logic [CNT_W-1:0]   x_q, x_d;
  logic [CNT_W-1:0]   y_q, y_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;

  // decode of the current position
  logic       tick_int;
  logic       h_wrap;
  logic       v_wrap;
  logic       at_origin;
  logic       h_act;
  logic       v_act;
  logic       h_in_sync;
  logic       v_in_sync;
  logic [1:0] scale_eff;

  always_comb begin
    tick_int  = en && (div_cnt_q == '0);
    h_wrap    = (h_q == H_LAST);
    v_wrap    = (v_q == V_LAST);
    at_origin = (h_q == '0) && (v_q == '0);
    h_act     = (h_q < H_ACT);
    v_act     = (v_q < V_ACT);
    h_in_sync = (h_q >= H_SS) && (h_q <= H_SE);
    v_in_sync = (v_q >= V_SS) && (v_q <= V_SE);
    // the frame's first pixel already uses the newly sampled scale
    scale_eff = at_origin ? scale : scale_q;
  end

  always_comb begin
    div_cnt_d     = div_cnt_q;
    h_d           = h_q;
    v_d           = v_q;
    scale_d       = scale_q;
    frame_cnt_d   = frame_cnt_q;
    pix_tick_d    = 1'b0;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (en) begin
      if (div_cnt_q == DIV_LAST) begin
        div_cnt_d = '0;
      end else begin
        div_cnt_d = div_cnt_q + DIV_ONE;
      end
    end

    if (tick_int) begin
      pix_tick_d    = 1'b1;
      hsync_d       = h_in_sync ? HS_POL : ~HS_POL;
      vsync_d       = v_in_sync ? VS_POL : ~VS_POL;
      de_d          = h_act && v_act;
      x_d           = (h_act && v_act) ? (h_q >> scale_eff) : '0;
      y_d           = (h_act && v_act) ? (v_q >> scale_eff) : '0;
      line_start_d  = (h_q == '0);
      frame_start_d = at_origin;

      if (at_origin) begin
        scale_d     = scale;
        frame_cnt_d = frame_cnt_q + FRM_ONE;
      end

      if (h_wrap) begin
        h_d = '0;
        if (v_wrap) begin
          v_d = '0;
        end else begin
          v_d = v_q + CNT_ONE;
        end
      end else begin
        h_d = h_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q     <= '0;
      h_q           <= '0;
      v_q           <= '0;
      scale_q       <= '0;
      frame_cnt_q   <= '0;
      pix_tick_q    <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      h_q           <= h_d;
      v_q           <= v_d;
      scale_q       <= scale_d;
      frame_cnt_q   <= frame_cnt_d;
      pix_tick_q    <= pix_tick_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_tick    = pix_tick_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen on a 16x8 raster,
// one instance at PIX_DIV=1 (a_*) and one at PIX_DIV=3 (b_*).
module tb_vga_timing_gen;

  localparam int CW = 10;
  localparam int FW = 8;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic [1:0] scale;

  logic a_tick, a_hs, a_vs, a_de, a_ls, a_fs;
  logic [CW-1:0] a_x, a_y;
  logic [FW-1:0] a_fc;
  logic b_tick, b_hs, b_vs, b_de, b_ls, b_fs;
  logic [CW-1:0] b_x, b_y;
  logic [FW-1:0] b_fc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_DIV(1),
    .CNT_W(CW), .FRAME_W(FW)
  ) u_a (
    .clk(clk), .rst(rst), .en(en), .scale(scale),
    .pix_tick(a_tick), .hsync(a_hs), .vsync(a_vs), .de(a_de),
    .x(a_x), .y(a_y), .line_start(a_ls), .frame_start(a_fs),
    .frame_cnt(a_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_DIV(3),
    .CNT_W(CW), .FRAME_W(FW)
  ) u_b (
    .clk(clk), .rst(rst), .en(en), .scale(scale),
    .pix_tick(b_tick), .hsync(b_hs), .vsync(b_vs), .de(b_de),
    .x(b_x), .y(b_y), .line_start(b_ls), .frame_start(b_fs),
    .frame_cnt(b_fc)
  );

  typedef struct {
    logic       en;
    logic [1:0] sc;
    logic       tick, hs, vs, de, ls, fs;
    int         x, y, fc;
  } vec_t;

  vec_t tbl[20];

  function automatic logic [33:0] pk(
    input logic tk, input logic hs, input logic vs,
    input logic de, input logic ls, input logic fs,
    input int x, input int y, input int fc);
    return {tk, hs, vs, de, ls, fs, 10'(x), 10'(y), 8'(fc)};
  endfunction

  function automatic logic [33:0] obs_a();
    return {a_tick, a_hs, a_vs, a_de, a_ls, a_fs, a_x, a_y, a_fc};
  endfunction

  function automatic logic [33:0] obs_b();
    return {b_tick, b_hs, b_vs, b_de, b_ls, b_fs, b_x, b_y, b_fc};
  endfunction

  // expected outputs after the tick that showed pixel index t of a run
  function automatic logic [33:0] mdl(
    input int t, input int sc, input logic tk);
    int h;
    int v;
    logic d;
    h = t % 16;
    v = (t / 16) % 8;
    d = (h < 8) && (v < 4);
    return pk(tk, !(h >= 10 && h <= 12), !(v >= 5 && v <= 6), d,
              tk && (h == 0), tk && (h == 0) && (v == 0),
              d ? (h >> sc) : 0, d ? (v >> sc) : 0,
              (t / 128 + 1) % 256);
  endfunction

  task automatic chk(input string nm, input logic [33:0] act,
                     input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input logic [1:0] sc);
    en = 1'b0;
    scale = sc;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  localparam logic [33:0] RST_V = {6'b011000, 28'd0};

  initial begin
    int n_ls;
    int n_fs;
    int n_vs;
    int n_de;
    int n_hs;
    int t;

    for (int i = 0; i < 20; i++) begin
      tbl[i] = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1};
    end
    tbl[0].ls = 1'b1;
    tbl[0].fs = 1'b1;
    for (int i = 1; i < 8; i++) tbl[i].x = i;
    for (int i = 8; i < 16; i++) tbl[i].de = 1'b0;
    tbl[10].hs = 1'b0;
    tbl[11].hs = 1'b0;
    tbl[12].hs = 1'b0;
    tbl[16].ls = 1'b1;
    tbl[16].y = 1;
    tbl[17].x = 1;
    tbl[17].y = 1;
    tbl[18] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 1};
    tbl[19].x = 2;
    tbl[19].y = 1;

    rst = 1'b1;
    en = 1'b0;
    scale = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", obs_a(), RST_V);
    chk("reset_b", obs_b(), RST_V);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      en = tbl[i].en;
      scale = tbl[i].sc;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), obs_a(),
          pk(tbl[i].tick, tbl[i].hs, tbl[i].vs, tbl[i].de, tbl[i].ls,
             tbl[i].fs, tbl[i].x, tbl[i].y, tbl[i].fc));
    end

    do_reset(2'd0);
    en = 1'b1;
    n_ls = 0; n_fs = 0; n_vs = 0; n_de = 0; n_hs = 0;
    for (int n = 0; n <= 256 * 128; n++) begin
      @(posedge clk);
      #1;
      chk("run_a", obs_a(), mdl(n, 0, 1'b1));
      if (n < 768) chk("run_b", obs_b(), mdl(n / 3, 0, (n % 3) == 0));
      if (n < 400) begin
        n_ls += int'(a_ls);
        n_fs += int'(a_fs);
      end
      if (n < 128) begin
        n_vs += int'(!a_vs);
        n_de += int'(a_de);
      end
      if (n < 16) n_hs += int'(!a_hs);
      if (n == 80) chk("vs_start", {33'd0, a_vs}, 34'd0);
      if (n == 256 * 128 - 129) chk("fc_255", {26'd0, a_fc}, 34'd255);
      if (n == 255 * 128) chk("fc_wrap", {26'd0, a_fc}, 34'd0);
    end
    chk("ls_count", 34'(n_ls), 34'd25);
    chk("fs_count", 34'(n_fs), 34'd4);
    chk("vs_low", 34'(n_vs), 34'd32);
    chk("de_count", 34'(n_de), 34'd32);
    chk("hs_low", 34'(n_hs), 34'd3);

    do_reset(2'd1);
    en = 1'b1;
    for (int n = 0; n < 260; n++) begin
      if (n == 20) scale = 2'd0;
      @(posedge clk);
      #1;
      chk("scale", obs_a(), mdl(n, (n < 128) ? 1 : 0, 1'b1));
    end

    do_reset(2'd0);
    t = 0;
    for (int c = 0; c <= 60; c++) begin
      en = !(c >= 6 && c <= 25);
      @(posedge clk);
      #1;
      if (en) begin
        chk("freeze_run", obs_a(), mdl(t, 0, 1'b1));
        t++;
      end else begin
        chk("freeze_hold", obs_a(), mdl(t - 1, 0, 1'b0));
      end
      if (c == 26) chk("resume_x", {24'd0, a_x}, 34'd6);
      if (c == 36) chk("resume_ls", {33'd0, a_ls}, 34'd1);
    end

    do_reset(2'd0);
    en = 1'b1;
    repeat (50) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_a", obs_a(), RST_V);
    chk("async_rst_b", obs_b(), RST_V);
    @(posedge clk);
    #1;
    en = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_idle", obs_a(), RST_V);
    en = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_fs_a", obs_a(), mdl(0, 0, 1'b1));
    chk("post_rst_fs_b", obs_b(), mdl(0, 0, 1'b1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
